// File: rtl/keypad_lock_if.sv
// Keypad-to-display bus for the PIN lock: debounced key in, digit bank and status out.
interface keypad_lock_if;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [23:0] disp_digits;
   logic [5:0]  disp_blank;
   logic        unlocked;
   logic        locked_out;
   logic        prog_mode;
   logic [1:0]  fail_cnt;
   logic        err_pulse;

   modport master (
      output key_code, key_valid,
      input  disp_digits, disp_blank, unlocked, locked_out, prog_mode, fail_cnt, err_pulse
   );

   modport slave (
      input  key_code, key_valid,
      output disp_digits, disp_blank, unlocked, locked_out, prog_mode, fail_cnt, err_pulse
   );
endinterface

// File: rtl/keypad_lock_ctrl.sv
// PIN-entry lock sequencer driving a 6-digit seven-segment bank.
// Optional KEYLOCK_MASK_EN: accepted digits display as 8 while the true value is kept for comparison.
module keypad_lock_ctrl #(
   parameter int unsigned CODE_LEN       = 4,
   parameter logic [23:0] DEFAULT_CODE   = 24'h001234,
   parameter int unsigned MAX_FAIL       = 3,
   parameter int unsigned UNLOCK_CYCLES  = 250000000,
   parameter int unsigned LOCKOUT_CYCLES = 500000000
) (
   input logic           CLOCK_50,
   input logic           Reset,
   keypad_lock_if.slave  bus
);

   localparam int unsigned CNT_W     = 3;
   localparam int unsigned TMR_W     = 32;
   localparam logic [23:0] CODE_MASK = 24'((25'h1 << (4 * CODE_LEN)) - 25'h1);
   localparam logic [CNT_W-1:0] LEN  = CNT_W'(CODE_LEN);
   localparam logic [CNT_W-1:0] MAXF = CNT_W'(MAX_FAIL);
   localparam logic [TMR_W-1:0] UNLOCK_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
   localparam logic [TMR_W-1:0] LOCKOUT_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ENTRY, S_CHECK, S_UNLOCKED, S_PROG, S_LOCKOUT
   } state_t;

   state_t             state, state_n;
   logic [23:0]        digits, digits_n;
   logic [5:0]         blank, blank_n;
   logic [23:0]        entry, entry_n;
   logic [CNT_W-1:0]   count, count_n;
   logic [23:0]        code, code_n;
   logic [1:0]         fails, fails_n;
   logic [TMR_W-1:0]   timer, timer_n;
   logic               last_valid;
   logic               err_n;
   logic               unlocked_q, locked_q, prog_q, err_q;
   logic               do_shift, do_clear;

   logic key_edge, is_digit, timer_zero;
   logic [3:0] shown_digit;

   assign key_edge   = bus.key_valid & ~last_valid;
   assign is_digit   = (bus.key_code <= 4'd9);
   assign timer_zero = (timer == '0);
`ifdef KEYLOCK_MASK_EN
   assign shown_digit = 4'h8;
`else
   assign shown_digit = bus.key_code;
`endif

   always_ff @(posedge CLOCK_50) begin
      if (!Reset) begin
         state      <= S_IDLE;
         digits     <= '0;
         blank      <= 6'b111111;
         entry      <= '0;
         count      <= '0;
         code       <= DEFAULT_CODE & CODE_MASK;
         fails      <= '0;
         timer      <= '0;
         last_valid <= 1'b0;
         unlocked_q <= 1'b0;
         locked_q   <= 1'b0;
         prog_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_n;
         digits     <= digits_n;
         blank      <= blank_n;
         entry      <= entry_n;
         count      <= count_n;
         code       <= code_n;
         fails      <= fails_n;
         timer      <= timer_n;
         last_valid <= bus.key_valid;
         unlocked_q <= (state_n == S_UNLOCKED) || (state_n == S_PROG);
         locked_q   <= (state_n == S_LOCKOUT);
         prog_q     <= (state_n == S_PROG);
         err_q      <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      digits_n = digits;
      blank_n  = blank;
      entry_n  = entry;
      count_n  = count;
      code_n   = code;
      fails_n  = fails;
      timer_n  = timer;
      err_n    = 1'b0;
      do_shift = 1'b0;
      do_clear = 1'b0;

      // Timed states count down every cycle; expiry takes priority over any key edge.
      if (state == S_UNLOCKED || state == S_PROG || state == S_LOCKOUT)
         timer_n = timer - TMR_W'(1);

      case (state)
         S_IDLE, S_ENTRY: begin
            if (key_edge) begin
               if (is_digit) begin
                  if (count < LEN) begin
                     do_shift = 1'b1;
                     state_n  = S_ENTRY;
                  end
               end else if (bus.key_code == 4'hE) begin
                  do_clear = 1'b1;
                  state_n  = S_IDLE;
               end else if (bus.key_code == 4'hF) begin
                  state_n = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            do_clear = 1'b1;
            if (count == LEN && (entry & CODE_MASK) == code) begin
               fails_n = '0;
               state_n = S_UNLOCKED;
               timer_n = UNLOCK_LOAD;
            end else begin
               err_n = 1'b1;
               if (CNT_W'(fails) + CNT_W'(1) == MAXF) begin
                  fails_n = 2'(MAX_FAIL);
                  state_n = S_LOCKOUT;
                  timer_n = LOCKOUT_LOAD;
               end else begin
                  fails_n = fails + 2'd1;
                  state_n = S_IDLE;
               end
            end
         end
         S_UNLOCKED: begin
            if (timer_zero) begin
               state_n = S_IDLE;
            end else if (key_edge) begin
               if (bus.key_code == 4'hF) begin
                  state_n = S_IDLE;
               end else if (bus.key_code == 4'hA) begin
                  do_clear = 1'b1;
                  state_n  = S_PROG;
                  timer_n  = UNLOCK_LOAD;
               end
            end
         end
         S_PROG: begin
            // Leaving PROG without storing discards any partial entry.
            if (timer_zero) begin
               do_clear = 1'b1;
               state_n  = S_IDLE;
            end else if (key_edge) begin
               if (is_digit) begin
                  if (count < LEN) do_shift = 1'b1;
               end else if (bus.key_code == 4'hF) begin
                  if (count == LEN) begin
                     code_n   = entry & CODE_MASK;
                     do_clear = 1'b1;
                     state_n  = S_IDLE;
                  end
               end else if (bus.key_code == 4'hE) begin
                  do_clear = 1'b1;
                  state_n  = S_IDLE;
               end
            end
         end
         S_LOCKOUT: begin
            if (timer_zero) begin
               fails_n = '0;
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      if (do_clear) begin
         digits_n = '0;
         blank_n  = 6'b111111;
         entry_n  = '0;
         count_n  = '0;
      end else if (do_shift) begin
         digits_n = {digits[19:0], shown_digit};
         blank_n  = {blank[4:0], 1'b0};
         entry_n  = {entry[19:0], bus.key_code};
         count_n  = count + CNT_W'(1);
      end
   end

   assign bus.disp_digits = digits;
   assign bus.disp_blank  = blank;
   assign bus.unlocked    = unlocked_q;
   assign bus.locked_out  = locked_q;
   assign bus.prog_mode   = prog_q;
   assign bus.fail_cnt    = fails;
   assign bus.err_pulse   = err_q;

endmodule

// File: doc/keypad_lock_ctrl.md
Name: keypad_lock_ctrl

Overview:
- Sequencing controller between the keypad debouncer (key code plus valid level) and the 6-digit seven-segment bank.
- Turns debounced keystrokes into a PIN-entry lock: digit entry, clear, enter/compare, unlock timeout, code reprogramming, and lockout after repeated failures.
- Owns the shift-in display registers and drives the 24-bit digit bus and 6-bit blank-zero flags consumed by the seven-segment decoders.

Parameters:
- CODE_LEN, 4, number of digits in a code (1..6).
- DEFAULT_CODE, 24'h001234, code loaded at reset; low 4*CODE_LEN bits used, one BCD nibble per digit.
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (1..3).
- UNLOCK_CYCLES, 250000000, clocks spent in UNLOCKED or PROG before auto-relock.
- LOCKOUT_CYCLES, 500000000, clocks spent in LOCKOUT.

Ports:
- CLOCK_50 in 1: system clock, all logic on posedge.
- Reset in 1: synchronous, active-low.
- key_code in 4: debounced key value. 0-9 are digits, A is program, B-D are ignored, E (*) is clear, F (#) is enter.
- key_valid in 1: debounced valid level. Keystroke = rising edge.
- disp_digits out 24: digit i on [4i+3:4i]; digit 0 is rightmost.
- disp_blank out 6: blank-zero flag per digit; 1 = digit blanked when its value is 0.
- unlocked out 1: high in UNLOCKED and PROG.
- locked_out out 1: high in LOCKOUT.
- prog_mode out 1: high in PROG.
- fail_cnt out 2: consecutive failures.
- err_pulse out 1: one-cycle pulse on a failed check.

Behaviour:
- Interface: reset Reset, synchronous, active-low; clock CLOCK_50.
- Reset values:
  - state = IDLE; entry buffer = 0; count = 0.
  - disp_digits = 0; disp_blank = 6'b111111, so the display is fully blank.
  - unlocked = locked_out = prog_mode = err_pulse = 0; fail_cnt = 0.
  - stored code = DEFAULT_CODE; last_valid = 0.
- Reset mid-operation restores everything above. Any reprogrammed code is lost.
- Key edge detection:
  - edge = key_valid & ~last_valid; last_valid is registered every cycle.
  - If key_valid is already high on the first cycle after reset, that counts as an edge.
  - Holding a key produces exactly one edge.
- Keystroke effects are visible on the cycle after the edge. All outputs are registered.
- Display shift, applied on each accepted digit:
  - digits[5:1] <= digits[4:0]; digit0 <= key_code.
  - disp_blank[5:1] <= disp_blank[4:0]; disp_blank[0] <= 0.
- Display clear means digits = 0 and disp_blank = 111111. Clear also zeroes the entry buffer and count.
- States:
  - IDLE / ENTRY:
    - Digit with count < CODE_LEN: shift into the buffer and display, count++, go to ENTRY.
    - Digit with count = CODE_LEN: ignored.
    - E: display clear, go to IDLE; fail_cnt unchanged.
    - F: go to CHECK.
    - A and B-D: ignored.
  - CHECK (exactly one cycle; key edges in this cycle are dropped):
    - Match requires count = CODE_LEN and buffer = stored code. On match: fail_cnt = 0, display clear, go to UNLOCKED, load the timer with UNLOCK_CYCLES-1.
    - Otherwise err_pulse = 1 for one cycle and display clear.
    - If fail_cnt+1 = MAX_FAIL: go to LOCKOUT, load the timer with LOCKOUT_CYCLES-1, fail_cnt holds MAX_FAIL.
    - Else fail_cnt++ and go to IDLE.
  - UNLOCKED:
    - F: go to IDLE (manual relock).
    - A: go to PROG, display clear, timer reloads.
    - Timer reaching 0: go to IDLE.
    - Other keys: ignored.
  - PROG:
    - Digit entry as in ENTRY.
    - F with count = CODE_LEN: store the buffer as the new code, display clear, go to IDLE.
    - F with count < CODE_LEN: ignored.
    - E: abort, code unchanged, go to IDLE.
    - Timer reaching 0: go to IDLE, code unchanged.
  - LOCKOUT:
    - All keys ignored; edges are still tracked, so a key held at exit does not fire.
    - Timer reaching 0: fail_cnt = 0, go to IDLE.
- Timer: 32-bit down counter that decrements every cycle in UNLOCKED, PROG and LOCKOUT.
- Simultaneous events: if a timer expiry and a key edge land in the same cycle, the expiry wins and the key is dropped.

Optional Feature:
- Macro KEYLOCK_MASK_EN.
- Defined: each accepted digit shifts 4'h8 into the display instead of its value; the entry buffer still holds the true value. Comparison and all state behaviour are unchanged.
- Undefined: the display shows the true digits.

Test Plan:
- Reset, then keys 1,2,3,4,F (defaults, UNLOCK_CYCLES=20):
  - after 1,2,3,4: disp_digits = 24'h001234, disp_blank = 6'b110000;
  - after F: unlocked = 1 two cycles later, fail_cnt = 0;
  - unlocked drops exactly 20 cycles after entering UNLOCKED.
- Keys 9,9,9,9,F three times (MAX_FAIL=3, LOCKOUT_CYCLES=30):
  - err_pulse three times; fail_cnt steps 1 then 2;
  - locked_out = 1 for 30 cycles;
  - key 1 during lockout leaves disp_digits = 0;
  - after exit fail_cnt = 0.
- Keys 1,2,E,1,2,3,4,5:
  - E clears to blank with fail_cnt unchanged;
  - the fifth digit is ignored, so disp_digits = 24'h001234;
  - F then unlocks.
- Unlock, then A,5,6,7,8,F:
  - returns to IDLE;
  - entering 1,2,3,4,F fails (err_pulse);
  - entering 5,6,7,8,F unlocks;
  - pulsing Reset restores 1234.
- key_valid held high for 100 cycles with key_code = 3 -> exactly one digit is shifted in.
- Timer expiry in UNLOCKED coinciding with an A-key edge -> state goes to IDLE, prog_mode stays 0.
